// File: rtl/pe_pkg.sv
// Shared definitions for the MAC processing element: controller states,
// dataflow mode encoding and the signed saturation limits.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pe_state_t;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  // Limits are built in a wide container and sliced down by the user,
  // so one function serves every accumulator width up to LIM_W bits.
  localparam int LIM_W = 128;

  // Largest positive value of an acc_w-bit two's-complement number.
  function automatic logic [LIM_W-1:0] sat_max(input int acc_w);
    logic [LIM_W-1:0] one;
    one = LIM_W'(1);
    return (one << (acc_w - 1)) - one;
  endfunction

  // Most negative value of an acc_w-bit number (low acc_w bits are 100..0).
  function automatic logic [LIM_W-1:0] sat_min(input int acc_w);
    return ~sat_max(acc_w);
  endfunction

endpackage

// File: rtl/pe_mac_cfg_sat_add.sv
// Signed adder with one guard bit. Flags overflow and either clamps the
// result to the representable range or keeps the wrapped low bits.
module sat_add
  import pe_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter bit SAT   = 1'b1
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  localparam logic [LIM_W-1:0] MAX_FULL = sat_max(ACC_W);
  localparam logic [LIM_W-1:0] MIN_FULL = sat_min(ACC_W);
  localparam logic [ACC_W-1:0] MAX_V    = MAX_FULL[ACC_W-1:0];
  localparam logic [ACC_W-1:0] MIN_V    = MIN_FULL[ACC_W-1:0];

  logic [ACC_W:0] wide;

  assign wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
  assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];

  // Pick the wrapped sum, or the limit on the side the guard bit points to.
  always_comb begin
    sum = wide[ACC_W-1:0];
    if (SAT && ovf) begin
      sum = wide[ACC_W] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/pe_mac_cfg.sv
// Systolic-array processing element with selectable dataflow:
// weight-stationary (psum flows down) or output-stationary (local acc).
module pe_mac_cfg
  import pe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int SAT    = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              start,
  input  logic              stop,
  input  logic              w_load,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_valid_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_valid_in,
  input  logic [ACC_W-1:0]  psum_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_valid_out,
  output logic [ACC_W-1:0]  psum_out,
  output logic              psum_valid,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  output logic              busy,
  output logic              ovf,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(2);

  pe_state_t                  state, state_nxt;
  logic                       mode_q;
  logic signed [DATA_W-1:0]   w_reg;
  logic signed [ACC_W-1:0]    acc;
  logic                       a_vq, b_vq;

  logic                       run, start_ok, do_mac;
  logic signed [DATA_W-1:0]   mul_b;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    addend;
  logic signed [ACC_W-1:0]    mac_sum;
  logic                       mac_ovf;

  assign run      = (state == RUN);
  assign start_ok = (state == IDLE) && start;
  assign do_mac   = run && a_valid_in && ((mode_q == MODE_WS) || b_valid_in);

  assign mul_b    = (mode_q == MODE_OS) ? $signed(b_in) : w_reg;
  assign prod     = $signed(a_in) * mul_b;
  assign prod_ext = ACC_W'(prod);
  assign addend   = (mode_q == MODE_OS) ? acc : $signed(psum_in);

  sat_add #(
    .ACC_W (ACC_W),
    .SAT   (SAT != 0)
  ) u_sat_add (
    .a   (addend),
    .b   (prod_ext),
    .sum (mac_sum),
    .ovf (mac_ovf)
  );

  assign acc_out     = acc;
  assign a_valid_out = a_vq && run;
  assign b_valid_out = b_vq && run;

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic plus the state-decoded status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    acc_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (stop) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        acc_valid = (mode_q == MODE_OS);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Mode is captured when a run begins; the weight only loads while idle
  // and start wins if both arrive together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_WS;
      w_reg  <= '0;
    end else if (start_ok) begin
      mode_q <= mode;
    end else if ((state == IDLE) && w_load) begin
      w_reg  <= $signed(w_in);
    end
  end

  // Output-stationary accumulator and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (start_ok) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (do_mac) begin
      if (mode_q == MODE_OS) acc <= mac_sum;
      if (mac_ovf)           ovf <= 1'b1;
    end
  end

  // Weight-stationary partial sum passed to the PE below; holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psum_out   <= '0;
      psum_valid <= 1'b0;
    end else begin
      psum_valid <= do_mac && (mode_q == MODE_WS);
      if (do_mac && (mode_q == MODE_WS)) psum_out <= mac_sum;
    end
  end

  // Operand forwarding to neighbouring PEs with one cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      a_vq  <= 1'b0;
      b_vq  <= 1'b0;
    end else if (run) begin
      a_out <= a_in;
      b_out <= b_in;
      a_vq  <= a_valid_in;
      b_vq  <= b_valid_in;
    end else begin
      a_vq  <= 1'b0;
      b_vq  <= 1'b0;
    end
  end

  // Operation counter: two ops (multiply + add) per MAC, sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (do_mac) begin
      if (op_count > CNT_MAX - CNT_INC) op_count <= CNT_MAX;
      else                              op_count <= op_count + CNT_INC;
    end
  end

endmodule

// File: tb/tb_pe_mac_cfg.sv
// Testbench for pe_mac_cfg: a saturating and a wrapping instance share the
// same stimulus and are compared every cycle against a behavioural model.
module tb_pe_mac_cfg;

  localparam longint MAXV     = 64'sd2147483647;
  localparam longint MINV     = -64'sd2147483648;
  localparam longint CNT_MAXL = 64'sd4294967295;

  logic        clk, rst;
  logic        mode, start, stop, w_load, a_valid_in, b_valid_in;
  logic [15:0] w_in, a_in, b_in;
  logic [31:0] psum_in;

  logic [15:0] s_a_out, s_b_out, w_a_out, w_b_out;
  logic        s_av, s_bv, s_pv, s_accv, s_busy, s_ovf;
  logic        w_av, w_bv, w_pv, w_accv, w_busy, w_ovf;
  logic [31:0] s_psum, s_acc, s_cnt, w_psum, w_acc, w_cnt;

  int n_errors = 0;
  int n_checks = 0;

  // Model state: 0 idle, 1 running, 2 draining.
  int          m_state;
  bit          m_mode, m_pv, m_ovf_s, m_ovf_w, m_av, m_bv;
  longint      m_w, m_acc_s, m_acc_w, m_psum_s, m_psum_w, m_cnt;
  logic [15:0] m_a, m_b;

  pe_mac_cfg #(.DATA_W(16), .ACC_W(32), .SAT(1), .CNT_W(32)) dut_s (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .stop(stop),
    .w_load(w_load), .w_in(w_in), .a_in(a_in), .a_valid_in(a_valid_in),
    .b_in(b_in), .b_valid_in(b_valid_in), .psum_in(psum_in),
    .a_out(s_a_out), .a_valid_out(s_av), .b_out(s_b_out), .b_valid_out(s_bv),
    .psum_out(s_psum), .psum_valid(s_pv), .acc_out(s_acc), .acc_valid(s_accv),
    .busy(s_busy), .ovf(s_ovf), .op_count(s_cnt));

  pe_mac_cfg #(.DATA_W(16), .ACC_W(32), .SAT(0), .CNT_W(32)) dut_w (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .stop(stop),
    .w_load(w_load), .w_in(w_in), .a_in(a_in), .a_valid_in(a_valid_in),
    .b_in(b_in), .b_valid_in(b_valid_in), .psum_in(psum_in),
    .a_out(w_a_out), .a_valid_out(w_av), .b_out(w_b_out), .b_valid_out(w_bv),
    .psum_out(w_psum), .psum_valid(w_pv), .acc_out(w_acc), .acc_valid(w_accv),
    .busy(w_busy), .ovf(w_ovf), .op_count(w_cnt));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint sx16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sx32(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [31:0] lo32(input longint v);
    return v[31:0];
  endfunction

  function automatic bit outOfRange(input longint s);
    return (s > MAXV) || (s < MINV);
  endfunction

  function automatic longint clampS(input longint s);
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
  endfunction

  function automatic longint wrap32(input longint s);
    return sx32(s[31:0]);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_state = 0;  m_mode = 0;  m_pv = 0;  m_ovf_s = 0;  m_ovf_w = 0;
    m_av = 0;  m_bv = 0;  m_w = 0;  m_acc_s = 0;  m_acc_w = 0;
    m_psum_s = 0;  m_psum_w = 0;  m_cnt = 0;  m_a = '0;  m_b = '0;
  endtask

  // One clock of the reference behaviour, applied to the inputs just sampled.
  task automatic modelStep();
    int     prev;
    bit     mac;
    longint p, s;
    prev = m_state;
    mac  = (prev == 1) && a_valid_in && (!m_mode || b_valid_in);
    m_pv = mac && !m_mode;
    if (mac) begin
      p = sx16(a_in) * (m_mode ? sx16(b_in) : m_w);
      if (!m_mode) begin
        s = sx32(psum_in) + p;
        m_psum_s = clampS(s);
        m_psum_w = wrap32(s);
        if (outOfRange(s)) begin m_ovf_s = 1; m_ovf_w = 1; end
      end else begin
        s = m_acc_s + p;
        if (outOfRange(s)) m_ovf_s = 1;
        m_acc_s = clampS(s);
        s = m_acc_w + p;
        if (outOfRange(s)) m_ovf_w = 1;
        m_acc_w = wrap32(s);
      end
      m_cnt = (m_cnt + 2 > CNT_MAXL) ? CNT_MAXL : m_cnt + 2;
    end
    m_av = (prev == 1) && a_valid_in;
    m_bv = (prev == 1) && b_valid_in;
    if (prev == 1) begin m_a = a_in; m_b = b_in; end
    case (prev)
      0: begin
        if (start) begin
          m_state = 1;  m_mode = mode;
          m_acc_s = 0;  m_acc_w = 0;  m_ovf_s = 0;  m_ovf_w = 0;
        end else if (w_load) begin
          m_w = sx16(w_in);
        end
      end
      1: if (stop) m_state = 2;
      default: m_state = 0;
    endcase
  endtask

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("S.psum_out",   s_psum, lo32(m_psum_s));
      checkOutput("W.psum_out",   w_psum, lo32(m_psum_w));
      checkOutput("S.psum_valid", s_pv,   m_pv);
      checkOutput("W.psum_valid", w_pv,   m_pv);
      checkOutput("S.acc_out",    s_acc,  lo32(m_acc_s));
      checkOutput("W.acc_out",    w_acc,  lo32(m_acc_w));
      checkOutput("S.acc_valid",  s_accv, (m_state == 2) && m_mode);
      checkOutput("W.acc_valid",  w_accv, (m_state == 2) && m_mode);
      checkOutput("S.busy",       s_busy, m_state != 0);
      checkOutput("W.busy",       w_busy, m_state != 0);
      checkOutput("S.ovf",        s_ovf,  m_ovf_s);
      checkOutput("W.ovf",        w_ovf,  m_ovf_w);
      checkOutput("S.op_count",   s_cnt,  lo32(m_cnt));
      checkOutput("W.op_count",   w_cnt,  lo32(m_cnt));
      checkOutput("S.a_out",      s_a_out, m_a);
      checkOutput("W.a_out",      w_a_out, m_a);
      checkOutput("S.b_out",      s_b_out, m_b);
      checkOutput("W.b_out",      w_b_out, m_b);
      checkOutput("S.a_valid_out", s_av, m_av && (m_state == 1));
      checkOutput("W.a_valid_out", w_av, m_av && (m_state == 1));
      checkOutput("S.b_valid_out", s_bv, m_bv && (m_state == 1));
      checkOutput("W.b_valid_out", w_bv, m_bv && (m_state == 1));
    end
  end

  // Drive one cycle of inputs, advance the model on the clock edge and
  // return just after the following falling edge.
  task automatic applyStimulus(input bit st, input bit sp, input bit md, input bit wl,
                               input logic [15:0] wi, input bit av, input logic [15:0] a,
                               input bit bv, input logic [15:0] b, input logic [31:0] ps);
    start = st;  stop = sp;  mode = md;  w_load = wl;  w_in = wi;
    a_valid_in = av;  a_in = a;  b_valid_in = bv;  b_in = b;  psum_in = ps;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 16'd0, 0, 16'd0, 0, 16'd0, 32'd0);
  endtask

  task automatic osPair(input logic [15:0] a, input logic [15:0] b, input bit sp);
    applyStimulus(0, sp, 0, 0, 16'd0, 1, a, 1, b, 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;  mode = 0;  start = 0;  stop = 0;  w_load = 0;  w_in = '0;
    a_in = '0;  a_valid_in = 0;  b_in = '0;  b_valid_in = 0;  psum_in = '0;
    modelReset();
    doReset();
    checkOutput("reset busy",     s_busy, 1'b0);
    checkOutput("reset op_count", s_cnt,  32'd0);

    // Weight-stationary: 10 + 5*3 = 25.
    applyStimulus(0, 0, 0, 1, 16'd3, 0, 16'd0, 0, 16'd0, 32'd0);
    applyStimulus(1, 0, 0, 0, 16'd0, 0, 16'd0, 0, 16'd0, 32'd0);
    applyStimulus(0, 0, 0, 0, 16'd0, 1, 16'd5, 0, 16'd0, 32'd10);
    checkOutput("ws psum_out",   s_psum, 32'd25);
    checkOutput("ws psum_valid", s_pv,   1'b1);
    checkOutput("ws op_count",   s_cnt,  32'd2);
    applyStimulus(0, 1, 0, 0, 16'd0, 0, 16'd0, 0, 16'd0, 32'd0);
    idleCycle();

    // Output-stationary: 2*3 + 4*(-1) + (-6)*2 = -10.
    doReset();
    applyStimulus(1, 0, 1, 0, 16'd0, 0, 16'd0, 0, 16'd0, 32'd0);
    osPair(16'd2, 16'd3, 0);
    osPair(16'd4, 16'hFFFF, 0);
    osPair(16'hFFFA, 16'd2, 0);
    applyStimulus(0, 1, 0, 0, 16'd0, 0, 16'd0, 0, 16'd0, 32'd0);
    checkOutput("os acc_valid", s_accv, 1'b1);
    checkOutput("os acc_out",   s_acc,  32'hFFFF_FFF6);
    checkOutput("os op_count",  s_cnt,  32'd6);
    idleCycle();
    checkOutput("os acc_valid drop", s_accv, 1'b0);

    // Overflow: build 0x7FFF_FFF0, then add 0x20.
    doReset();
    applyStimulus(1, 0, 1, 0, 16'd0, 0, 16'd0, 0, 16'd0, 32'd0);
    osPair(16'h8000, 16'h8001, 0);
    osPair(16'h8000, 16'h8001, 0);
    osPair(16'd4095, 16'd16, 0);
    checkOutput("pre-ovf acc S", s_acc, 32'h7FFF_FFF0);
    osPair(16'd2, 16'd16, 0);
    checkOutput("sat acc",  s_acc, 32'h7FFF_FFFF);
    checkOutput("sat ovf",  s_ovf, 1'b1);
    // 0x7FFF_FFF0 + 0x20 wraps to 0x8000_0010.
    checkOutput("wrap acc", w_acc, 32'h8000_0010);
    checkOutput("wrap ovf", w_ovf, 1'b1);
    osPair(16'hFFFF, 16'd1, 0);
    checkOutput("sat acc after -1",  s_acc, 32'h7FFF_FFFE);
    checkOutput("wrap acc after -1", w_acc, 32'h8000_000F);
    checkOutput("sat ovf sticky",    s_ovf, 1'b1);
    checkOutput("wrap ovf sticky",   w_ovf, 1'b1);
    applyStimulus(0, 1, 0, 0, 16'd0, 0, 16'd0, 0, 16'd0, 32'd0);
    idleCycle();
    checkOutput("ovf held in idle", s_ovf, 1'b1);
    applyStimulus(1, 0, 1, 0, 16'd0, 0, 16'd0, 0, 16'd0, 32'd0);
    checkOutput("sat ovf cleared",  s_ovf, 1'b0);
    checkOutput("wrap ovf cleared", w_ovf, 1'b0);
    applyStimulus(0, 1, 0, 0, 16'd0, 0, 16'd0, 0, 16'd0, 32'd0);
    idleCycle();

    // Collisions: start beats w_load; stop keeps its MAC.
    doReset();
    applyStimulus(0, 0, 0, 1, 16'd2, 0, 16'd0, 0, 16'd0, 32'd0);
    applyStimulus(1, 0, 0, 1, 16'd7, 0, 16'd0, 0, 16'd0, 32'd0);
    applyStimulus(0, 0, 0, 0, 16'd0, 1, 16'd1, 0, 16'd0, 32'd0);
    checkOutput("start beats w_load", s_psum, 32'd2);
    applyStimulus(0, 1, 0, 0, 16'd0, 0, 16'd0, 0, 16'd0, 32'd0);
    idleCycle();
    applyStimulus(1, 0, 1, 0, 16'd0, 0, 16'd0, 0, 16'd0, 32'd0);
    osPair(16'd3, 16'd3, 0);
    osPair(16'd2, 16'd5, 1);
    checkOutput("stop keeps MAC acc", s_acc,  32'd19);
    checkOutput("stop keeps MAC vld", s_accv, 1'b1);
    idleCycle();

    // Asynchronous reset in the middle of a run.
    applyStimulus(1, 0, 1, 0, 16'd0, 0, 16'd0, 0, 16'd0, 32'd0);
    osPair(16'd3, 16'd4, 0);
    checkOutput("busy before rst", s_busy, 1'b1);
    start = 0;  stop = 0;  a_valid_in = 1;  b_valid_in = 1;  a_in = 16'd5;  b_in = 16'd5;
    @(posedge clk);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("async busy",     s_busy, 1'b0);
    checkOutput("async acc_out",  s_acc,  32'd0);
    checkOutput("async op_count", s_cnt,  32'd0);
    checkOutput("async a_out",    s_a_out, 16'd0);
    checkOutput("async a_valid",  s_av,   1'b0);
    checkOutput("async psum_out", s_psum, 32'd0);
    a_valid_in = 0;  b_valid_in = 0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1, 0, 1, 0, 16'd0, 0, 16'd0, 0, 16'd0, 32'd0);
    osPair(16'd2, 16'd2, 1);
    checkOutput("post-rst acc_out", s_acc, 32'd4);
    idleCycle();

    // Randomised traffic, including mode flips and w_load attempts mid-run.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
      applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
                    1'($urandom), $urandom_range(0, 3) == 0, 16'($urandom),
                    $urandom_range(0, 3) != 0, ra, $urandom_range(0, 3) != 0, rb,
                    32'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_mac_cfg.md
PE_MAC_CFG -- requirements
Module: pe_mac_cfg

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed operand width.
REQ-002 SHALL have parameter ACC_W, default 32, signed accumulator/partial-sum width (ACC_W >= 2*DATA_W).
REQ-003 SHALL have parameter SAT, default 1, where 1 means saturate on overflow and 0 means two's-complement wrap.
REQ-004 SHALL have parameter CNT_W, default 32, op-counter width.
REQ-005 SHALL have ports (name, direction, width, meaning): clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-006 SHALL have ports mode in 1 (0 = weight-stationary WS, 1 = output-stationary OS); start in 1; stop in 1; w_load in 1; w_in in DATA_W weight.
REQ-007 SHALL have ports a_in in DATA_W activation from left; a_valid_in in 1; b_in in DATA_W operand from above (OS); b_valid_in in 1; psum_in in ACC_W partial sum from above (WS).
REQ-008 SHALL have ports a_out out DATA_W; a_valid_out out 1; b_out out DATA_W; b_valid_out out 1; psum_out out ACC_W; psum_valid out 1.
REQ-009 SHALL have ports acc_out out ACC_W (OS result); acc_valid out 1; busy out 1; ovf out 1 (sticky); op_count out CNT_W.

Function
REQ-010 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-011 SHALL transition IDLE->RUN on start, RUN->DRAIN on stop, and DRAIN->IDLE unconditionally after 1 cycle.
REQ-012 SHALL latch mode on the start cycle; mode changes in RUN/DRAIN SHALL be ignored.
REQ-013 SHALL capture w_in into the weight register in IDLE when w_load=1; w_load outside IDLE SHALL be ignored.
REQ-014 SHALL, when start and w_load coincide in IDLE, honour start and not load the weight.
REQ-015 SHALL on start clear acc to 0 and clear ovf.
REQ-016 SHALL ignore start while in RUN or DRAIN.
REQ-017 SHALL in RUN register a_out<=a_in, a_valid_out<=a_valid_in, b_out<=b_in and b_valid_out<=b_valid_in (1-cycle latency).
REQ-018 SHALL drive a_valid_out and b_valid_out to 0 outside RUN.
REQ-019 SHALL in WS mode, in RUN with a_valid_in=1, produce psum_out <= psum_in + a_in*w_reg with psum_valid=1 on the next cycle; otherwise psum_valid=0 and psum_out SHALL hold its value.
REQ-020 SHALL in OS mode, in RUN with a_valid_in=1 and b_valid_in=1, update acc <= acc + a_in*b_in; if either valid is low, acc SHALL hold.
REQ-021 SHALL keep psum_valid=0 in OS mode.
REQ-022 SHALL in DRAIN drive acc_out=acc and acc_valid=1 for exactly 1 cycle (OS only); acc_valid SHALL be 0 at all other times.
REQ-023 SHALL compute each product at full 2*DATA_W precision, sign-extend it, and form the sum at ACC_W+1 bits.
REQ-024 SHALL, on overflow, clamp the result to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) when SAT=1 and keep the low ACC_W bits when SAT=0.
REQ-025 SHALL set ovf on any overflowing MAC regardless of SAT; ovf SHALL remain set until rst or start.
REQ-026 SHALL increment op_count by 2 per performed MAC and saturate it at all-ones (no wrap); op_count SHALL NOT be cleared by start.
REQ-027 SHALL, when stop coincides with valid inputs in RUN, perform that MAC before entering DRAIN.
REQ-028 SHALL assert busy in RUN and DRAIN.

Reset
REQ-029 SHALL on rst (any time, including mid-RUN) force state=IDLE and set w_reg, acc, psum_out, a_out and b_out to 0.
REQ-030 SHALL on rst set all valid outputs, ovf and busy to 0 and op_count to 0.
REQ-031 SHALL on rst discard any in-flight MAC without updating op_count.

Structure
REQ-032 SHALL take the state enum (IDLE/RUN/DRAIN), mode encoding constants (MODE_WS=0, MODE_OS=1) and the saturation limit functions from a shared package pe_pkg.
REQ-033 SHALL contain one sub-module, sat_add, that performs the ACC_W+1-bit add, applies the SAT clamp/wrap, and outputs the overflow flag; it SHALL be combinational and parametrised by ACC_W and SAT.

Verification
REQ-034 SHALL verify WS mode: w_load with w_in=3, then start, a_in=5, psum_in=10, valid -> psum_out=25 and psum_valid=1 one cycle later, op_count=2.
REQ-035 SHALL verify OS mode: start, then pairs (2,3), (4,-1), (-6,2) all valid, then stop -> acc_valid pulse with acc_out=-10, op_count=6.
REQ-036 SHALL verify saturation: SAT=1, ACC_W=32, OS mode, acc driven to 0x7FFF_FFF0 and a MAC adding 0x20 -> acc=0x7FFF_FFFF and ovf=1; ovf still 1 after further non-overflowing MACs, and 0 after the next start.
REQ-037 SHALL verify wrap: SAT=0, same stimulus as REQ-036 -> acc=0x8000_000F and ovf=1.
REQ-038 SHALL verify collisions: start with w_load=1 and w_in=7 -> w_reg unchanged; stop with a valid pair -> MAC included in acc_out.
REQ-039 SHALL verify reset mid-RUN: rst asserted during RUN -> all outputs 0 and state IDLE immediately (asynchronously); subsequent start operates normally.
